// File: rtl/iact_pkg.sv
// Shared types and default geometry for the input-activation scratchpad.
package iact_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam int ACT_SIZE    = 5;
  localparam int KERNEL_SIZE = 3;
  localparam int NUM_OUT     = ACT_SIZE - KERNEL_SIZE + 1;
  localparam int WIN         = KERNEL_SIZE * KERNEL_SIZE;
  localparam int N_READS     = NUM_OUT * NUM_OUT * WIN;
  localparam int PLANE       = ACT_SIZE * ACT_SIZE;

endpackage

// File: rtl/spad_ram_1r1w.sv
// Simple dual-port scratchpad RAM: synchronous write, registered read.
// Only the read register is reset; the array keeps its contents.
module spad_ram_1r1w #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds between reads so the stream output stays stable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/spad_iact.sv
// Input-activation scratchpad: captures one act_size^2 plane, replays it in sliding-window order.
// Define SPAD_IACT_REUSE_EN to keep the plane valid after a stream for repeated replays.
module spad_iact
  import iact_pkg::*;
#(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int act_size           = ACT_SIZE,
  parameter int kernel_size        = KERNEL_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_BITWIDTH-1:0] w_data_spad,
  input  logic                     load_en_spad,
  input  logic                     start_conv,
  output logic                     load_done,
  output logic                     load_err,
  output logic                     busy,
  output logic [DATA_BITWIDTH-1:0] r_data_iact,
  output logic                     r_valid_iact,
  output logic                     window_last,
  output logic                     conv_done
);

  localparam int AW        = ADDR_BITWIDTH_SPAD;
  localparam int NUM_OUT_L = act_size - kernel_size + 1;
  localparam int PLANE_L   = act_size * act_size;

  localparam logic [AW-1:0] ONE        = AW'(1);
  localparam logic [AW-1:0] OUT_LAST   = AW'(NUM_OUT_L - 1);
  localparam logic [AW-1:0] KER_LAST   = AW'(kernel_size - 1);
  localparam logic [AW-1:0] PLANE_LAST = AW'(PLANE_L - 1);
  localparam logic [AW-1:0] ACT_W      = AW'(act_size);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] r, c, i, j;
  logic [AW-1:0] rd_addr;
  logic          wr_en, rd_en, accept;
  logic          last_elem, last_addr;

  assign last_elem = (i == KER_LAST) && (j == KER_LAST);
  assign last_addr = last_elem && (r == OUT_LAST) && (c == OUT_LAST);
  assign rd_addr   = (r + i) * ACT_W + (c + j);
  assign busy      = (state == READ) || r_valid_iact;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A simultaneous load beats start_conv; the final element still in flight also blocks it.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        wr_en  = load_en_spad;
        accept = start_conv && load_done && !load_en_spad && !r_valid_iact;
        if (accept) begin
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (last_addr) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters wrap to zero on the final address, ready for the next stream.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r <= '0;
      c <= '0;
      i <= '0;
      j <= '0;
    end else if (rd_en) begin
      if (j != KER_LAST) begin
        j <= j + ONE;
      end else begin
        j <= '0;
        if (i != KER_LAST) begin
          i <= i + ONE;
        end else begin
          i <= '0;
          if (c != OUT_LAST) begin
            c <= c + ONE;
          end else begin
            c <= '0;
            r <= (r == OUT_LAST) ? '0 : r + ONE;
          end
        end
      end
    end
  end

  // wr_ptr is already 0 whenever load_done is set, so a fresh plane starts at address 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr    <= (wr_ptr == PLANE_LAST) ? '0 : wr_ptr + ONE;
        load_done <= (wr_ptr == PLANE_LAST);
      end
`ifdef SPAD_IACT_REUSE_EN
`else
      else if (rd_en && last_addr) begin
        load_done <= 1'b0;
      end
`endif
      if ((state == READ) && load_en_spad) begin
        load_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid_iact <= 1'b0;
      window_last  <= 1'b0;
      conv_done    <= 1'b0;
    end else begin
      r_valid_iact <= rd_en;
      window_last  <= rd_en && last_elem;
      conv_done    <= rd_en && last_addr;
    end
  end

  spad_ram_1r1w #(
    .DATA_W(DATA_BITWIDTH),
    .ADDR_W(AW)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(w_data_spad),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(r_data_iact)
  );

endmodule

// File: tb/tb_spad_iact.sv
// Bench for spad_iact: phase-based behavioural model checked every cycle plus directed literal checks.
module tb_spad_iact;

  localparam int A   = 5;
  localparam int K   = 3;
  localparam int NO  = A - K + 1;
  localparam int WIN = K * K;
  localparam int N   = NO * NO * WIN;
  localparam int PL  = A * A;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] w_data_spad;
  logic        load_en_spad;
  logic        start_conv;
  logic        load_done, load_err, busy;
  logic [15:0] r_data_iact;
  logic        r_valid_iact, window_last, conv_done;

  always #5 clk = ~clk;

  spad_iact dut (
    .clk         (clk),
    .reset       (reset),
    .w_data_spad (w_data_spad),
    .load_en_spad(load_en_spad),
    .start_conv  (start_conv),
    .load_done   (load_done),
    .load_err    (load_err),
    .busy        (busy),
    .r_data_iact (r_data_iact),
    .r_valid_iact(r_valid_iact),
    .window_last (window_last),
    .conv_done   (conv_done)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_phase counts cycles since an accepted start (0 = not streaming).
  logic [15:0] m_plane [PL];
  logic [15:0] m_snap  [PL];
  int          m_cnt, m_phase;
  bit          m_done, m_err;
  logic [15:0] m_last;

  function automatic logic [15:0] exp_val(input int k);
    int w, e, rr, cc, ii, jj;
    w  = k / WIN;
    e  = k % WIN;
    rr = w / NO;
    cc = w % NO;
    ii = e / K;
    jj = e % K;
    return m_snap[(rr + ii) * A + cc + jj];
  endfunction

  always @(posedge clk) begin
    bit rd, acc;
    if (!reset) begin
      m_cnt = 0; m_phase = 0; m_done = 0; m_err = 0; m_last = '0;
    end else begin
      rd  = (m_phase >= 1) && (m_phase <= N);
      acc = start_conv && m_done && !load_en_spad && (m_phase == 0);
      if (load_en_spad) begin
        if (rd) m_err = 1;
        else begin
          m_plane[m_cnt] = w_data_spad;
          m_cnt++;
          if (m_cnt == PL) begin m_cnt = 0; m_done = 1; end
          else m_done = 0;
        end
      end
`ifndef SPAD_IACT_REUSE_EN
      if (m_phase == N) m_done = 0;
`endif
      if (m_phase >= 2) m_last = exp_val(m_phase - 2);
      if (m_phase != 0) m_phase = (m_phase == N + 1) ? 0 : m_phase + 1;
      if (acc) begin m_phase = 1; m_snap = m_plane; end
    end
  end

  logic [15:0] cap[$];
  logic [15:0] prev[$];
  int          busy_cycles;

  always @(negedge clk) begin
    bit v;
    if (run_chk) begin
      v = (m_phase >= 2);
      chk("busy", busy, m_phase != 0);
      chk("r_valid_iact", r_valid_iact, v);
      chk("r_data_iact", r_data_iact, v ? exp_val(m_phase - 2) : m_last);
      chk("window_last", window_last, v && ((m_phase - 2) % WIN == WIN - 1));
      chk("conv_done", conv_done, m_phase == N + 1);
      chk("load_done", load_done, m_done);
      chk("load_err", load_err, m_err);
      if (r_valid_iact) cap.push_back(r_data_iact);
      if (busy) busy_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input int base, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      load_en_spad = 1'b1;
      w_data_spad  = 16'(base + k);
      if (k == cnt - 1) chk("load_done_before_last", load_done, 0);
      tick();
    end
    load_en_spad = 1'b0;
  endtask

  task automatic wait_conv();
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      if (conv_done) seen = 1;
    end
    chk("conv_done_seen", seen, 1);
  endtask

  task automatic run_stream();
    cap.delete();
    busy_cycles  = 0;
    start_conv   = 1'b1;
    tick();
    start_conv   = 1'b0;
    wait_conv();
    tick();
  endtask

  task automatic check_golden(input string tag);
    int gf[9];
    int gl[9];
    gf = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    gl = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
    chk({tag, "_count"}, cap.size(), N);
    if (cap.size() == N) begin
      for (int k = 0; k < 9; k++) chk({tag, "_first"}, cap[k], gf[k]);
      for (int k = 0; k < 9; k++) chk({tag, "_last"}, cap[N - 9 + k], gl[k]);
    end
  endtask

  task automatic check_same(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_count"}, cap.size(), prev.size());
    if (cap.size() == prev.size())
      foreach (cap[k]) if (cap[k] !== prev[k]) bad++;
    chk({tag, "_diff_words"}, bad, 0);
  endtask

  initial begin
    reset        = 1'b0;
    load_en_spad = 1'b0;
    start_conv   = 1'b0;
    w_data_spad  = '0;
    tick();
    run_chk = 1'b1;
    tick();
    reset = 1'b1;
    chk("rst_load_done", load_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_r_data", r_data_iact, 0);

    // Full plane load, then one stream.
    load_words(0, 25);
    chk("load_done_after", load_done, 1);
    chk("busy_after_load", busy, 0);
    run_stream();
    check_golden("stream1");
    chk("busy_span", busy_cycles, N + 1);
    prev = cap;

    // Partial load: start must be ignored.
    load_words(0, 10);
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
    repeat (3) tick();
    chk("partial_busy", busy, 0);
    chk("partial_load_done", load_done, 0);
    load_words(10, 15);
    chk("partial_complete", load_done, 1);

    // Write strobe mid-stream.
    cap.delete();
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
    repeat (19) tick();
    load_en_spad = 1'b1;
    w_data_spad  = 16'hdead;
    tick();
    load_en_spad = 1'b0;
    wait_conv();
    tick();
    chk("load_err_sticky", load_err, 1);
    check_same("err_stream");

    // Reset mid-stream.
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
    repeat (39) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_load_done", load_done, 0);
    chk("mid_rst_load_err", load_err, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", r_valid_iact, 0);
    chk("mid_rst_data", r_data_iact, 0);
    chk("mid_rst_wlast", window_last, 0);
    chk("mid_rst_conv_done", conv_done, 0);
    load_words(0, 25);
    run_stream();
    check_golden("after_rst");
    prev = cap;

    // Second start right after conv_done.
`ifdef SPAD_IACT_REUSE_EN
    run_stream();
    check_same("reuse");
`else
    chk("noreuse_load_done", load_done, 0);
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
    repeat (3) tick();
    chk("noreuse_busy", busy, 0);
    chk("noreuse_load_done2", load_done, 0);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
